// File: rtl/draw_star_box.sv
//------------------------------------------------------------------------------
// Module      : draw_star_box
// Description : Pixel-plot writer for the VGA adapter. When goDraw arrives it
//               captures the star bounding box, grows it by MARGIN with edge
//               clamping, and plots the outline one pixel per clock. When the
//               box is done (or the request is rejected) it pulses doneDraw.
//               Define DRAW_STAR_BOX_FILL_EN to plot the whole box instead of
//               the outline, row-major with x varying fastest.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module draw_star_box #(
  parameter int         XSZ        = 8,
  parameter int         YSZ        = 7,
  parameter int         X_MAX      = 159,
  parameter int         Y_MAX      = 119,
  parameter int         MARGIN     = 1,
  parameter logic [2:0] BOX_COLOUR = 3'b010
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           goDraw,
  input  logic [XSZ-1:0] xLeft,
  input  logic [XSZ-1:0] xRight,
  input  logic [YSZ-1:0] yTop,
  input  logic [YSZ-1:0] yBottom,
  output logic [XSZ-1:0] x,
  output logic [YSZ-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           doneDraw,
  output logic           boxErr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_TOP    = 3'd2,
    S_RIGHT  = 3'd3,
    S_BOTTOM = 3'd4,
    S_LEFT   = 3'd5,
    S_DONE   = 3'd6,
    S_FILL   = 3'd7
  } state_t;

  // One extra bit so that subtracting the margin shows up as a borrow.
  localparam logic [XSZ:0] c_margin_x = (XSZ+1)'(MARGIN);
  localparam logic [YSZ:0] c_margin_y = (YSZ+1)'(MARGIN);
  localparam logic [XSZ:0] c_x_max    = (XSZ+1)'(X_MAX);
  localparam logic [YSZ:0] c_y_max    = (YSZ+1)'(Y_MAX);

  state_t         r_state, w_state_nxt;
  logic [XSZ-1:0] r_l, r_r, r_cx, w_cx_nxt, w_x_nxt, w_l, w_r;
  logic [YSZ-1:0] r_t, r_b, r_cy, w_cy_nxt, w_y_nxt, w_t, w_b, w_h_m1;
  logic [XSZ:0]   w_l_ext, w_r_ext;
  logic [YSZ:0]   w_t_ext, w_b_ext;
  logic           w_plot_nxt, w_done_nxt, w_err_nxt, w_bad;

  // Margin growth with clamping to the screen edges, plus request validity.
  always_comb begin
    w_l_ext = {1'b0, xLeft} - c_margin_x;
    w_r_ext = {1'b0, xRight} + c_margin_x;
    w_t_ext = {1'b0, yTop} - c_margin_y;
    w_b_ext = {1'b0, yBottom} + c_margin_y;
    w_l     = w_l_ext[XSZ] ? '0 : w_l_ext[XSZ-1:0];
    w_r     = (w_r_ext > c_x_max) ? c_x_max[XSZ-1:0] : w_r_ext[XSZ-1:0];
    w_t     = w_t_ext[YSZ] ? '0 : w_t_ext[YSZ-1:0];
    w_b     = (w_b_ext > c_y_max) ? c_y_max[YSZ-1:0] : w_b_ext[YSZ-1:0];
    w_bad   = (xLeft > xRight) || (yTop > yBottom);
    w_h_m1  = r_b - r_t;
  end

  // Next-state and next-output logic; each edge-walking state emits the
  // current cursor and then advances it or hands over to the next edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cx_nxt    = r_cx;
    w_cy_nxt    = r_cy;
    w_x_nxt     = '0;
    w_y_nxt     = '0;
    w_plot_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = boxErr;
    if (r_state == S_TOP || r_state == S_RIGHT || r_state == S_BOTTOM ||
        r_state == S_LEFT || r_state == S_FILL) begin
      w_plot_nxt = 1'b1;
      w_x_nxt    = r_cx;
      w_y_nxt    = r_cy;
    end
    case (r_state)
      S_IDLE: if (goDraw) w_state_nxt = S_LATCH;
      S_LATCH: begin
        if (w_bad) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_err_nxt   = 1'b0;
          w_cx_nxt    = w_l;
          w_cy_nxt    = w_t;
`ifdef DRAW_STAR_BOX_FILL_EN
          w_state_nxt = S_FILL;
`else
          w_state_nxt = S_TOP;
`endif
        end
      end
      S_TOP: begin
        if (r_cx == r_r) begin
          if (r_t == r_b) w_state_nxt = S_DONE;
          else begin
            w_cy_nxt    = r_t + YSZ'(1);
            w_state_nxt = S_RIGHT;
          end
        end else w_cx_nxt = r_cx + XSZ'(1);
      end
      S_RIGHT: begin
        if (r_cy == r_b) begin
          if (r_l == r_r) w_state_nxt = S_DONE;
          else begin
            w_cx_nxt    = r_r - XSZ'(1);
            w_state_nxt = S_BOTTOM;
          end
        end else w_cy_nxt = r_cy + YSZ'(1);
      end
      S_BOTTOM: begin
        if (r_cx == r_l) begin
          if (w_h_m1 < YSZ'(2)) w_state_nxt = S_DONE;
          else begin
            w_cy_nxt    = r_b - YSZ'(1);
            w_state_nxt = S_LEFT;
          end
        end else w_cx_nxt = r_cx - XSZ'(1);
      end
      S_LEFT: begin
        if (r_cy == r_t + YSZ'(1)) w_state_nxt = S_DONE;
        else w_cy_nxt = r_cy - YSZ'(1);
      end
`ifdef DRAW_STAR_BOX_FILL_EN
      S_FILL: begin
        if (r_cx == r_r) begin
          if (r_cy == r_b) w_state_nxt = S_DONE;
          else begin
            w_cx_nxt = r_l;
            w_cy_nxt = r_cy + YSZ'(1);
          end
        end else w_cx_nxt = r_cx + XSZ'(1);
      end
`endif
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, bounds, cursor and registered outputs; reset aborts any draw.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_l      <= '0;
      r_r      <= '0;
      r_t      <= '0;
      r_b      <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      doneDraw <= 1'b0;
      boxErr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cx     <= w_cx_nxt;
      r_cy     <= w_cy_nxt;
      x        <= w_x_nxt;
      y        <= w_y_nxt;
      colour   <= w_plot_nxt ? BOX_COLOUR : 3'b000;
      plot     <= w_plot_nxt;
      doneDraw <= w_done_nxt;
      boxErr   <= w_err_nxt;
      if (r_state == S_LATCH) begin
        r_l <= w_l;
        r_r <= w_r;
        r_t <= w_t;
        r_b <= w_b;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_draw_star_box.sv
//------------------------------------------------------------------------------
// Module      : tb_draw_star_box
// Description : Directed self-checking bench for draw_star_box. Two instances
//               share the stimulus: one with MARGIN=0, one with MARGIN=1.
//               Expected pixel orders follow DRAW_STAR_BOX_FILL_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_draw_star_box;

  logic       clk = 1'b0;
  logic       resetn, goDraw;
  logic [7:0] xLeft, xRight;
  logic [6:0] yTop, yBottom;
  logic [7:0] x0, x1, ox;
  logic [6:0] y0, y1, oy;
  logic [2:0] c0, c1, oc;
  logic       p0, p1, d0, d1, e0, e1, op, od, oe;
  int         sel = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  draw_star_box #(.MARGIN(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .goDraw(goDraw),
    .xLeft(xLeft), .xRight(xRight), .yTop(yTop), .yBottom(yBottom),
    .x(x0), .y(y0), .colour(c0), .plot(p0), .doneDraw(d0), .boxErr(e0)
  );

  draw_star_box #(.MARGIN(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .goDraw(goDraw),
    .xLeft(xLeft), .xRight(xRight), .yTop(yTop), .yBottom(yBottom),
    .x(x1), .y(y1), .colour(c1), .plot(p1), .doneDraw(d1), .boxErr(e1)
  );

  // Observe whichever instance the current test targets.
  always_comb begin
    ox = (sel != 0) ? x1 : x0;
    oy = (sel != 0) ? y1 : y0;
    oc = (sel != 0) ? c1 : c0;
    op = (sel != 0) ? p1 : p0;
    od = (sel != 0) ? d1 : d0;
    oe = (sel != 0) ? e1 : e0;
  end

  function automatic int px(input int xv, input int yv);
    return xv * 128 + yv;
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request, hold goDraw for 'hold' sampling edges, and check the
  // plotted pixels, their timing, the done pulse and the error flag.
  task automatic run_box(input string tag, input int xl, input int xr, input int yt,
                         input int yb, input int exp_q[$], input int hold, input bit exp_err);
    int idx = 0;
    int first_k = -1;
    int done_k = -1;
    @(negedge clk);
    xLeft = xl[7:0]; xRight = xr[7:0]; yTop = yt[6:0]; yBottom = yb[6:0];
    goDraw = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == hold - 1) goDraw = 1'b0;
      if (op) begin
        if (first_k < 0) first_k = k;
        if (idx < exp_q.size())
          chk_val({tag, " pixel"}, {17'b0, ox, oy}, exp_q[idx]);
        chk_val({tag, " colour"}, {29'b0, oc}, 32'd2);
        idx++;
      end
      if (od) begin
        done_k = k;
        break;
      end
    end
    goDraw = 1'b0;
    chk_val({tag, " count"}, idx, exp_q.size());
    chk_val({tag, " done_cycle"}, done_k, 2 + exp_q.size());
    if (exp_q.size() > 0) chk_val({tag, " first_cycle"}, first_k, 2);
    chk_val({tag, " boxErr"}, {31'b0, oe}, {31'b0, exp_err});
    repeat (40) @(negedge clk);
  endtask

  int q1[$], q2[$], q3a[$], q3b[$], q6[$];
  int nplot;

  initial begin
`ifdef DRAW_STAR_BOX_FILL_EN
    q1 = '{px(10,20), px(11,20), px(12,20), px(10,21), px(11,21), px(12,21),
           px(10,22), px(11,22), px(12,22)};
    q2 = '{px(0,0), px(1,0), px(0,1), px(1,1)};
`else
    q1 = '{px(10,20), px(11,20), px(12,20), px(12,21), px(12,22), px(11,22),
           px(10,22), px(10,21)};
    q2 = '{px(0,0), px(1,0), px(1,1), px(0,1)};
`endif
    q3a = '{px(5,7)};
    q3b = '{px(3,9), px(4,9), px(5,9), px(6,9)};
    q6 = '{};

    resetn = 1'b0; goDraw = 1'b0;
    xLeft = '0; xRight = '0; yTop = '0; yBottom = '0;
    repeat (3) @(negedge clk);
    chk_val("reset plot", {31'b0, p0}, 0);
    chk_val("reset xy", {17'b0, x0, y0}, 0);
    chk_val("reset colour", {29'b0, c0}, 0);
    chk_val("reset done", {31'b0, d0}, 0);
    chk_val("reset boxErr", {31'b0, e0}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    sel = 0; run_box("t1", 10, 12, 20, 22, q1, 1, 1'b0);
    sel = 1; run_box("t2", 0, 0, 0, 0, q2, 1, 1'b0);
    sel = 0; run_box("t3a", 5, 5, 7, 7, q3a, 1, 1'b0);
    sel = 0; run_box("t3b", 3, 6, 9, 9, q3b, 1, 1'b0);
    sel = 0; run_box("t4", 20, 10, 5, 8, q6, 1, 1'b1);
    sel = 0; run_box("t4clr", 10, 12, 20, 22, q1, 1, 1'b0);

    // Reset in the middle of a draw, right after the third plot.
    sel = 0;
    @(negedge clk);
    xLeft = 8'd10; xRight = 8'd12; yTop = 7'd20; yBottom = 7'd22;
    goDraw = 1'b1;
    nplot = 0;
    for (int k = 0; k < 50 && nplot < 3; k++) begin
      @(negedge clk);
      goDraw = 1'b0;
      if (p0) nplot++;
    end
    chk_val("t5 plots_before_reset", nplot, 3);
    resetn = 1'b0;
    #1;
    chk_val("t5 reset plot", {31'b0, p0}, 0);
    chk_val("t5 reset xy", {17'b0, x0, y0}, 0);
    chk_val("t5 reset colour", {29'b0, c0}, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    nplot = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (p0 || d0) nplot++;
    end
    chk_val("t5 no_activity_after_reset", nplot, 0);
    run_box("t5 restart", 10, 12, 20, 22, q1, 1, 1'b0);
    run_box("t5 held_go", 10, 12, 20, 22, q1, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
